sprite_wr_arbiter: RTL and testbench

SPRITE_WR_ARBITER -- requirements
Module: sprite_wr_arbiter

---
 rtl/sprite_wr_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sprite_wr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_wr_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_wr_arbiter
//
// Arbitrates several sprite writers onto one BRAM write port. A writer owns
// the port for a burst. The burst ends on its last beat or after MAX_BURST
// beats. Ownership then rotates round-robin. Every accepted beat appears on
// the write port one clock later.
//
// Optional feature: define WR_BLANK_GATE_EN to confine grants and beat
// transfers to VGA blanking (blank=1). A burst simply pauses while blank=0.
// When the macro is undefined, blank is ignored, although the port remains.
//
// Parameters
//   ram_add_width : sprite BRAM address width
//   NR_OF_WRITERS : number of write requesters (>= 2)
//   MAX_BURST     : maximum beats per grant (>= 1)
//
// Ports
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   blank         : VGA blanking flag
//   req_valid     : per-writer beat valid
//   req_last      : per-writer "this beat ends the burst"
//   req_add/data  : per-writer beat address / RGB444 data
//   req_ready     : per-writer accept (beat moves when valid & ready)
//   wr_add/data   : registered BRAM write address / data
//   wr_req        : one-cycle write strobe per accepted beat
//   grant_valid   : a burst is in progress
//   grant_id      : current (or most recent) burst owner
// ---------------------------------------------------------------------------
module sprite_wr_arbiter #(
    parameter int ram_add_width = 8,
    parameter int NR_OF_WRITERS = 2,
    parameter int MAX_BURST     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               blank,
    input  logic [NR_OF_WRITERS-1:0]           req_valid,
    input  logic [NR_OF_WRITERS-1:0]           req_last,
    input  logic [ram_add_width-1:0]           req_add  [NR_OF_WRITERS],
    input  logic [11:0]                        req_data [NR_OF_WRITERS],
    output logic [NR_OF_WRITERS-1:0]           req_ready,
    output logic [ram_add_width-1:0]           wr_add,
    output logic [11:0]                        wr_data,
    output logic                               wr_req,
    output logic                               grant_valid,
    output logic [$clog2(NR_OF_WRITERS)-1:0]   grant_id
);

    localparam int              ID_W    = $clog2(NR_OF_WRITERS);
    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NR_OF_WRITERS - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                arb_en_q;
    logic                gate;
    logic                accept;
    logic                burst_end;

    logic                      wr_req_p1;
    logic [ram_add_width-1:0]  wr_add_p1;
    logic [11:0]               wr_data_p1;

    // First requester at or above ptr wins. If there is none, the first
    // requester below ptr wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NR_OF_WRITERS-1:0] valid,
                                                input logic [ID_W-1:0]          ptr);
        logic [ID_W-1:0] sel;
        logic            found;
        sel   = ptr;
        found = 1'b0;
        for (int c = 0; c < NR_OF_WRITERS; c++) begin
            if (!found && (c >= int'(ptr)) && valid[c]) begin
                sel   = ID_W'(c);
                found = 1'b1;
            end
        end
        for (int c = 0; c < NR_OF_WRITERS; c++) begin
            if (!found && valid[c]) begin
                sel   = ID_W'(c);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction

`ifdef WR_BLANK_GATE_EN
    assign gate = blank;
`else
    logic unused_blank;
    assign unused_blank = blank;
    assign gate         = 1'b1;
`endif

    // Ready depends only on registered state, so there is no combinational
    // path from req_valid to req_ready.
    always_comb begin
        req_ready = '0;
        if (state_q == BURST && gate)
            req_ready[owner_q] = 1'b1;
    end

    assign accept    = (state_q == BURST) && gate && req_valid[owner_q];
    assign cnt_inc   = cnt_q + 1'b1;
    // If req_last and the beat limit coincide, the burst ends only once.
    assign burst_end = accept && (req_last[owner_q] || (cnt_inc == MAX_CNT));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_en_q && gate && (|req_valid)) begin
                    state_d = BURST;
                    owner_d = rr_pick(req_valid, rr_ptr_q);
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (burst_end) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    rr_ptr_d = next_id(owner_q);
                end else if (accept) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // arb_en_q delays the first arbitration by one edge after reset release.
    // This keeps the first grant clear of the reset-removal edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            arb_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            arb_en_q <= 1'b1;
        end
    end

    // ---- stage p1: accepted beat registered onto the BRAM write port ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_req_p1  <= 1'b0;
            wr_add_p1  <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_req_p1 <= accept;
            if (accept) begin
                wr_add_p1  <= req_add[owner_q];
                wr_data_p1 <= req_data[owner_q];
            end
        end
    end

    assign wr_req      = wr_req_p1;
    assign wr_add      = wr_add_p1;
    assign wr_data     = wr_data_p1;
    assign grant_valid = (state_q == BURST);
    assign grant_id    = owner_q;

endmodule

// File: tb/tb_sprite_wr_arbiter.sv
module tb_sprite_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        blank;
    logic [1:0]  req_valid, req_last;
    logic [7:0]  req_add  [2];
    logic [11:0] req_data [2];
    logic [1:0]  req_ready;
    logic [7:0]  wr_add;
    logic [11:0] wr_data;
    logic        wr_req;
    logic        grant_valid;
    logic [0:0]  grant_id;

    sprite_wr_arbiter #(.ram_add_width(8), .NR_OF_WRITERS(2), .MAX_BURST(16)) dut (
        .clk(clk), .reset(reset), .blank(blank),
        .req_valid(req_valid), .req_last(req_last),
        .req_add(req_add), .req_data(req_data), .req_ready(req_ready),
        .wr_add(wr_add), .wr_data(wr_data), .wr_req(wr_req),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [1:0]  v, l;
        logic [7:0]  a0, a1;
        logic [11:0] d0, d1;
        logic [1:0]  rdy;
        logic        gv, gid, wrq;
        logic [7:0]  wa;
        logic [11:0] wd;
    } vec_t;
    vec_t tbl[13];

    // ---------------- handshake model state ----------------
    bit          ven[2];
    int          blen[2], total[2], nbeat[2], inb[2];
    logic [7:0]  act_log[$], exp_log[$];
    int          grant_log[$], exp_grant[$];
    bit          exp_pend;
    logic [7:0]  exp_a;
    logic [11:0] exp_d;
    logic        s_gv, prev_gv;
    logic [0:0]  s_gid;
    logic [1:0]  s_ready;
    int          gv_hi, gv_lo, run_hi, run_lo;

    function automatic logic [7:0] base(input int w);
        return (w == 1) ? 8'h40 : 8'h00;
    endfunction

    task automatic model_clear();
        for (int w = 0; w < 2; w++) begin
            ven[w] = 0; blen[w] = 0; total[w] = 0; nbeat[w] = 0; inb[w] = 0;
        end
        act_log.delete(); exp_log.delete(); grant_log.delete(); exp_grant.delete();
        exp_pend = 0; prev_gv = 0; gv_hi = 0; gv_lo = 0;
    endtask

    task automatic drive();
        for (int w = 0; w < 2; w++) begin
            req_valid[w] = ven[w] && (nbeat[w] < total[w]);
            req_add[w]   = base(w) + 8'(nbeat[w]);
            req_data[w]  = 12'(w * 256 + nbeat[w]);
            req_last[w]  = (blen[w] != 0) && (inb[w] + 1 == blen[w]);
        end
    endtask

    // One clock of the writers' behaviour: drive, sample at negedge, and check
    // the write port against the beat accepted in the previous cycle.
    task automatic step();
        logic [1:0] acc;
        drive();
        @(negedge clk);
        s_gv = grant_valid; s_gid = grant_id; s_ready = req_ready;
        if (grant_valid) gv_hi++; else gv_lo++;
        if (grant_valid && !prev_gv) grant_log.push_back(int'(grant_id));
        prev_gv = grant_valid;
        chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        chk("wr_req", wr_req, exp_pend);
        if (exp_pend) begin
            chk("wr_add", wr_add, exp_a);
            chk("wr_data", wr_data, exp_d);
        end
        if (wr_req) act_log.push_back(wr_add);
        acc = req_valid & req_ready;
        exp_pend = 0;
        for (int w = 0; w < 2; w++)
            if (acc[w]) begin
                exp_pend = 1; exp_a = req_add[w]; exp_d = req_data[w];
            end
        @(posedge clk); #1;
        for (int w = 0; w < 2; w++)
            if (acc[w]) begin
                nbeat[w]++;
                inb[w] = req_last[w] ? 0 : inb[w] + 1;
            end
    endtask

    function automatic bit all_done();
        return (!ven[0] || nbeat[0] >= total[0]) && (!ven[1] || nbeat[1] >= total[1]);
    endfunction

    task automatic run_until_done(input string name, input int budget);
        int n = 0;
        while (!all_done() && n < budget) begin
            step();
            n++;
        end
        chk({name, "_done"}, 32'(all_done()), 32'd1);
        run_hi = gv_hi; run_lo = gv_lo;
        step(); step();
    endtask

    task automatic cmp_logs(input string name);
        chk({name, "_nwr"}, act_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++)
            if (i < act_log.size()) chk({name, "_wr_seq"}, act_log[i], exp_log[i]);
        chk({name, "_ngrant"}, grant_log.size(), exp_grant.size());
        for (int i = 0; i < exp_grant.size(); i++)
            if (i < grant_log.size()) chk({name, "_grant_seq"}, grant_log[i], exp_grant[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1; blank = 1'b1; req_valid = '0; req_last = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0;
        int n;
        //          v     l     a0     a1     d0       d1       rdy   gv    gid   wrq   wa     wd
        tbl[0]  = '{2'b01,2'b00,8'h10,8'h00,12'hF00,12'h000, 2'b00,1'b0,1'b0,1'b0,8'h00,12'h000};
        tbl[1]  = '{2'b01,2'b00,8'h10,8'h00,12'hF00,12'h000, 2'b00,1'b0,1'b0,1'b0,8'h00,12'h000};
        tbl[2]  = '{2'b01,2'b00,8'h10,8'h00,12'hF00,12'h000, 2'b01,1'b1,1'b0,1'b0,8'h00,12'h000};
        tbl[3]  = '{2'b01,2'b00,8'h11,8'h00,12'hF00,12'h000, 2'b01,1'b1,1'b0,1'b1,8'h10,12'hF00};
        tbl[4]  = '{2'b01,2'b01,8'h12,8'h00,12'hF00,12'h000, 2'b01,1'b1,1'b0,1'b1,8'h11,12'hF00};
        tbl[5]  = '{2'b00,2'b00,8'h00,8'h00,12'h000,12'h000, 2'b00,1'b0,1'b0,1'b1,8'h12,12'hF00};
        tbl[6]  = '{2'b00,2'b00,8'h00,8'h00,12'h000,12'h000, 2'b00,1'b0,1'b0,1'b0,8'h12,12'hF00};
        tbl[7]  = '{2'b11,2'b11,8'h20,8'h30,12'h0A0,12'h00B, 2'b00,1'b0,1'b0,1'b0,8'h12,12'hF00};
        tbl[8]  = '{2'b11,2'b11,8'h20,8'h30,12'h0A0,12'h00B, 2'b10,1'b1,1'b1,1'b0,8'h12,12'hF00};
        tbl[9]  = '{2'b11,2'b11,8'h20,8'h30,12'h0A0,12'h00B, 2'b00,1'b0,1'b1,1'b1,8'h30,12'h00B};
        tbl[10] = '{2'b11,2'b11,8'h20,8'h30,12'h0A0,12'h00B, 2'b01,1'b1,1'b0,1'b0,8'h30,12'h00B};
        tbl[11] = '{2'b00,2'b00,8'h00,8'h00,12'h000,12'h000, 2'b00,1'b0,1'b0,1'b1,8'h20,12'h0A0};
        tbl[12] = '{2'b00,2'b00,8'h00,8'h00,12'h000,12'h000, 2'b00,1'b0,1'b0,1'b0,8'h20,12'h0A0};

        model_clear();
        reset = 1'b1; blank = 1'b1; req_valid = '0; req_last = '0;
        req_add[0] = '0; req_add[1] = '0; req_data[0] = '0; req_data[1] = '0;
        #1;
        chk("rst_wr_req", wr_req, 0);
        chk("rst_gv", grant_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wr_add", wr_add, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // 3-beat burst by writer0, then one-beat bursts alternating from rr_ptr=1
        for (int i = 0; i < 13; i++) begin
            req_valid = tbl[i].v; req_last = tbl[i].l;
            req_add[0] = tbl[i].a0; req_add[1] = tbl[i].a1;
            req_data[0] = tbl[i].d0; req_data[1] = tbl[i].d1;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_gv", i), grant_valid, tbl[i].gv);
            chk($sformatf("tbl%0d_gid", i), grant_id, tbl[i].gid);
            chk($sformatf("tbl%0d_wr_req", i), wr_req, tbl[i].wrq);
            chk($sformatf("tbl%0d_wr_add", i), wr_add, tbl[i].wa);
            chk($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].wd);
            @(posedge clk); #1;
        end

        // async reset in the middle of a writer1 burst
        do_reset();
        ven[1] = 1; total[1] = 100; blen[1] = 0;
        repeat (4) step();
        chk("midrst_pre_wr_req", wr_req, 1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_wr_req", wr_req, 0);
        chk("midrst_gv", grant_valid, 0);
        chk("midrst_gid", grant_id, 0);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_wr_add", wr_add, 0);
        chk("midrst_wr_data", wr_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        ven[0] = 1; total[0] = 1; blen[0] = 1;
        ven[1] = 1; total[1] = 100; blen[1] = 0;
        step(); chk("postrst_gv0", s_gv, 0);
        step(); chk("postrst_gv1", s_gv, 0);
        step(); chk("postrst_gv2", s_gv, 1);
        chk("postrst_gid", s_gid, 0);

        // both writers continuous, 2-beat bursts
        do_reset();
        ven[0] = 1; blen[0] = 2; total[0] = 4;
        ven[1] = 1; blen[1] = 2; total[1] = 4;
        run_until_done("alt", 100);
        chk("alt_gv_hi", run_hi, 8);
        chk("alt_gv_lo", run_lo, 5);
        exp_log = '{8'h00, 8'h01, 8'h40, 8'h41, 8'h02, 8'h03, 8'h42, 8'h43};
        exp_grant = '{0, 1, 0, 1};
        cmp_logs("alt");

        // writer1 streams 20 beats without last; writer0 joins during the burst
        do_reset();
        ven[1] = 1; blen[1] = 0; total[1] = 20;
        repeat (3) step();
        ven[0] = 1; blen[0] = 1; total[0] = 1;
        run_until_done("maxb", 200);
        for (int i = 0; i < 16; i++) exp_log.push_back(8'h40 + 8'(i));
        exp_log.push_back(8'h00);
        for (int i = 16; i < 20; i++) exp_log.push_back(8'h40 + 8'(i));
        exp_grant = '{1, 0, 1};
        cmp_logs("maxb");

        // owner drops valid for 5 cycles mid-burst
        do_reset();
        ven[0] = 1; blen[0] = 8; total[0] = 8;
        n = 0;
        while (nbeat[0] < 3 && n < 50) begin step(); n++; end
        ven[0] = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("gap_gv", s_gv, 1);
            chk("gap_gid", s_gid, 0);
        end
        chk("gap_nwr", act_log.size(), 3);
        ven[0] = 1;
        run_until_done("gap", 100);
        for (int i = 0; i < 8; i++) exp_log.push_back(8'(i));
        exp_grant = '{0};
        cmp_logs("gap");

        // blank low for 10 cycles mid-burst; burst of 16 with last on beat 16
        do_reset();
        ven[0] = 1; blen[0] = 16; total[0] = 16;
        n = 0;
        while (nbeat[0] < 4 && n < 50) begin step(); n++; end
        b0 = nbeat[0];
        blank = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("blank_gv", s_gv, 1);
`ifdef WR_BLANK_GATE_EN
            chk("blank_ready", s_ready, 2'b00);
`else
            chk("blank_ready", s_ready, 2'b01);
`endif
        end
`ifdef WR_BLANK_GATE_EN
        chk("blank_beats", nbeat[0], b0);
`else
        chk("blank_beats", nbeat[0], b0 + 10);
`endif
        blank = 1'b1;
        run_until_done("blank", 100);
        // last and the beat limit hit together: rr_ptr must be exactly 1
        ven[1] = 1; blen[1] = 1; total[1] = 1;
        blen[0] = 1; total[0] = 17; inb[0] = 0;
        run_until_done("lastmax", 100);
        for (int i = 0; i < 16; i++) exp_log.push_back(8'(i));
        exp_log.push_back(8'h40);
        exp_log.push_back(8'h10);
        exp_grant = '{0, 1, 0};
        cmp_logs("blank");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
